itrx_aib_phy_tx_ddr_src: RTL and testbench
==========================================

# itrx_aib_phy_tx_ddr_src

Upstream TX data-source stage for one AIB TX IO buffer cell. Registers functional DDR data, or a built-in test pattern (clock, PRBS7, fixed word), into `idat0q` and `idat1ql`. These two outputs feed the IO buffer's DDR and async muxes. It runs on the same per-cell launch clock that drives the DDR mux select, so the launch timing to the ubump is preserved.

## Interface
Parameters:
- `PRBS_SEED_DEF`, 7'h7F, LFSR seed used after reset and whenever `pat_seed` is zero.
- `CNT_W`, 16, width of `burst_len` and `pat_cnt`.

Ports:
- `ilaunch_clk`, in, 1, TX launch clock; the single clock of the block.
- `rst`, in, 1, synchronous, active-high reset.
- `tx_en`, in, 1, output enable; 0 forces the data outputs to 0.
- `idat0`, in, 1, functional data bit, first half of the DDR word.
- `idat1`, in, 1, functional data bit, second half of the DDR word.
- `pat_mode`, in, 2, source select: 0 FUNC, 1 CLK, 2 PRBS7, 3 FIXED.
- `pat_start`, in, 1, one-cycle pulse that starts a test run.
- `pat_stop`, in, 1, one-cycle pulse that aborts a run.
- `pat_seed`, in, 7, PRBS7 seed; in FIXED mode, `pat_seed[1:0]` is the fixed word.
- `burst_len`, in, CNT_W, run length in cycles; 0 means continuous.
- `idat0q`, out, 1, data bit registered on the rising edge.
- `idat1ql`, out, 1, data bit registered on the rising edge, then passed through a latch transparent while the clock is low.
- `pat_busy`, out, 1, high in LOAD and RUN.
- `pat_done`, out, 1, one-cycle pulse at the end of a run.
- `pat_cnt`, out, CNT_W, number of words emitted in the current or last run; saturates at all ones.

## Operation
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - If `pat_mode` = 0, the source is `{idat1, idat0}`.
  - Otherwise the source is 2'b00.
  - `pat_start` with `pat_mode` ≠ 0 moves to LOAD.
  - `pat_start` with `pat_mode` = 0 is ignored.
- LOAD, one cycle:
  - Latch `pat_mode` into `mode_q`.
  - Load the LFSR with `pat_seed`, or with `PRBS_SEED_DEF` if `pat_seed` is 0.
  - Load the remaining count from `burst_len`.
  - Clear `pat_cnt`.
  - Source is 2'b00.
  - Go to RUN.
- RUN: emit one 2-bit word per cycle and increment `pat_cnt`.
  - CLK: idat0 = 1, idat1 = 0.
  - PRBS7: two LFSR steps per cycle.
  - FIXED: `pat_seed[1:0]`, sampled in LOAD.
- Leaving RUN:
  - When the remaining count reaches 0 after `burst_len` = N cycles, go to IDLE and pulse `pat_done`.
  - `pat_stop` goes to IDLE on the next edge and also pulses `pat_done`.
- Ignored inputs:
  - `pat_start` while busy.
  - `pat_mode` changes while busy.
  - `pat_stop` in IDLE.
- PRBS7 polynomial x^7+x^6+1, one step:
  - fb = s[6]^s[5]
  - s <= {s[5:0], fb}
  - The output bit is fb.
  - The first step of a cycle drives idat0; the second drives idat1.
- `tx_en` = 0 forces the registered source to 2'b00. The FSM, LFSR and counters keep running.
- Reset:
  - FSM goes to IDLE and the LFSR to `PRBS_SEED_DEF`.
  - `pat_cnt`, `pat_busy`, `pat_done`, the `idat0q` register and the `idat1q` register go to 0.
  - `idat1ql` reaches 0 in the low phase after the reset edge.
- Reset mid-run aborts the run with no `pat_done` pulse.

## Timing
- Latency:
  - `idat0` to `idat0q` is one rising edge.
  - `idat1` to the `idat1q` register is one rising edge.
  - `idat1ql` follows the `idat1q` register during the low phase after that edge, and holds it through the following high phase.
- Wire order of word n: idat0 of n during the low phase of cycle n, then idat1 of n during the high phase of cycle n+1. Each mux input is stable while it is selected.
- `pat_start` at edge k:
  - LOAD at k+1.
  - First pattern word registered at edge k+2.
  - `pat_busy` high from k+1.
- Burst N started at edge k: the last word is at edge k+N+1; `pat_done` and `pat_busy` = 0 are at edge k+N+2.
- `pat_stop` takes effect at the next edge: that edge registers 2'b00. A simultaneous end of count gives a single `pat_done` pulse.

## Structure
- Shared package `itrx_aib_phy_tx_pkg` holds:
  - Mode encodings: `PAT_FUNC`, `PAT_CLK`, `PAT_PRBS7`, `PAT_FIXED`.
  - FSM state encodings.
- Sub-module `itrx_aib_phy_tx_prbs7`: 7-bit LFSR with a two-step-per-cycle output, plus load and seed-zero substitution.
- The `idat1ql` latch is an instantiated standard-cell latch wrapper.

## Test plan
- FUNC mode:
  - Stimulus: `tx_en` = 1; drive idat0/idat1 = 1/0, then 0/1, then 1/1.
  - Response: `idat0q` and `idat1ql` reproduce each pair one edge later; the wire order is idat0 then idat1.
- PRBS7 with seed 7'h7F:
  - Stimulus: start, `burst_len` = 200.
  - Response:
    - First 8 bits are 0,0,0,0,0,0,1,0.
    - LFSR state equals 7'h7F again after 127 cycles.
    - `pat_done` at start edge + 202.
    - `pat_cnt` = 200.
- CLK mode:
  - Stimulus: continuous run (`burst_len` = 0) for 50 cycles, then `pat_stop`.
  - Response: wire toggles every half cycle; after stop, `idat0q` = 0 and one `pat_done` pulse.
- Seed zero plus restart:
  - Stimulus: `pat_seed` = 0 → LFSR loads `PRBS_SEED_DEF`. Then, during RUN, pulse `pat_start` and change `pat_mode`.
  - Response: both are ignored and the sequence is unchanged.
- Reset mid-run:
  - Stimulus: assert `rst` at cycle 10 of PRBS7.
  - Response: next edge `idat0q` = 0, `pat_busy` = 0, no `pat_done`, `pat_cnt` = 0.
- Output enable:
  - Stimulus: `tx_en` = 0 during a FIXED run with word 2'b11.
  - Response: outputs are 0 while `pat_cnt` keeps incrementing.

Source files
------------

// File: rtl/itrx_aib_phy_tx_pkg.sv
// Shared types for the AIB TX data-source path.
//   pat_mode_e  : source select (functional data or one of three test patterns)
//   pat_state_e : pattern-generator FSM states
//   prbs7_step  : one step of the x^7+x^6+1 LFSR; the new bit lands in bit 0
package itrx_aib_phy_tx_pkg;

   typedef enum logic [1:0] {
      PAT_FUNC  = 2'd0,
      PAT_CLK   = 2'd1,
      PAT_PRBS7 = 2'd2,
      PAT_FIXED = 2'd3
   } pat_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } pat_state_e;

   function automatic logic [6:0] prbs7_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

endpackage

// File: rtl/itrx_aib_phy_tx_ddr_src_if.sv
// Control/data bundle between the TX cell controller and the DDR source stage.
//   master : drives enable, functional data, pattern controls; observes outputs
//   slave  : the source stage itself
interface itrx_aib_phy_tx_ddr_src_if #(
   parameter int CNT_W = 16
);
   logic             tx_en;
   logic             idat0;
   logic             idat1;
   logic [1:0]       pat_mode;
   logic             pat_start;
   logic             pat_stop;
   logic [6:0]       pat_seed;
   logic [CNT_W-1:0] burst_len;
   logic             idat0q;
   logic             idat1ql;
   logic             pat_busy;
   logic             pat_done;
   logic [CNT_W-1:0] pat_cnt;

   modport master (
      output tx_en, idat0, idat1, pat_mode, pat_start, pat_stop, pat_seed, burst_len,
      input  idat0q, idat1ql, pat_busy, pat_done, pat_cnt
   );

   modport slave (
      input  tx_en, idat0, idat1, pat_mode, pat_start, pat_stop, pat_seed, burst_len,
      output idat0q, idat1ql, pat_busy, pat_done, pat_cnt
   );
endinterface

// File: rtl/itrx_aib_phy_tx_latch.sv
// Standard-cell style D latch wrapper.
//   i_en : transparent while high
//   i_d  : data in
//   o_q  : data out, holds while i_en is low
module itrx_aib_phy_tx_latch (
   input  logic i_en,
   input  logic i_d,
   output logic o_q
);
   always_latch begin
      if (i_en) o_q <= i_d;
   end
endmodule

// File: rtl/itrx_aib_phy_tx_prbs7.sv
// PRBS7 (x^7+x^6+1) generator advancing two steps per clock.
//   i_clk/i_rst : clock, synchronous active-high reset (state -> SEED_DEF)
//   i_load      : load i_seed (SEED_DEF when i_seed is zero, which would lock up)
//   i_adv       : advance two steps
//   o_bits      : {second step bit, first step bit} of the current advance
module itrx_aib_phy_tx_prbs7
   import itrx_aib_phy_tx_pkg::*;
#(
   parameter logic [6:0] SEED_DEF = 7'h7F
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [6:0] i_seed,
   input  logic       i_adv,
   output logic [1:0] o_bits
);
   logic [6:0] r_lfsr;
   logic [6:0] w_s1;
   logic [6:0] w_s2;

   assign w_s1   = prbs7_step(r_lfsr);
   assign w_s2   = prbs7_step(w_s1);
   assign o_bits = {w_s2[0], w_s1[0]};

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_lfsr <= SEED_DEF;
      else if (i_load)
         r_lfsr <= (i_seed == 7'd0) ? SEED_DEF : i_seed;
      else if (i_adv)
         r_lfsr <= w_s2;
   end
endmodule

// File: rtl/itrx_aib_phy_tx_ddr_src.sv
// TX data-source stage for one AIB TX IO buffer cell. Registers functional DDR
// data or a test pattern (CLK, PRBS7, FIXED) on the launch clock.
//   ilaunch_clk : launch clock (same clock as the DDR mux select)
//   rst         : synchronous active-high reset
//   bus.slave   : tx_en, idat0/idat1, pat_* controls, burst_len in;
//                 idat0q, idat1ql, pat_busy, pat_done, pat_cnt out
// idat0q is driven on the low phase and idat1ql on the following high phase,
// so each mux input is stable while it is selected.
module itrx_aib_phy_tx_ddr_src
   import itrx_aib_phy_tx_pkg::*;
#(
   parameter logic [6:0] PRBS_SEED_DEF = 7'h7F,
   parameter int         CNT_W         = 16
) (
   input  logic                     ilaunch_clk,
   input  logic                     rst,
   itrx_aib_phy_tx_ddr_src_if.slave bus
);
   pat_state_e       r_state;
   pat_mode_e        r_mode_q;
   logic [1:0]       r_fixed;
   logic [CNT_W-1:0] r_rem;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cont;
   logic             r_end;
   logic             r_busy;
   logic             r_done;
   logic             r_idat0q;
   logic             r_idat1q;

   logic [1:0]       w_prbs;
   logic [1:0]       w_word;
   logic [1:0]       w_src;
   logic             w_run;
   logic             w_load;
   logic             w_stop;
   logic             w_last;
   logic             w_clk_n;
   logic             w_idat1ql;

   assign w_run  = (r_state == ST_RUN);
   assign w_load = (r_state == ST_LOAD);
   assign w_stop = w_run & bus.pat_stop;
   // burst_len == 0 loads r_cont, so the remaining count never ends the run
   assign w_last = w_run & ~r_cont & (r_rem == CNT_W'(1));

   itrx_aib_phy_tx_prbs7 #(.SEED_DEF(PRBS_SEED_DEF)) u_prbs (
      .i_clk  (ilaunch_clk),
      .i_rst  (rst),
      .i_load (w_load),
      .i_seed (bus.pat_seed),
      .i_adv  (w_run & ~w_stop),
      .o_bits (w_prbs)
   );

   always_comb begin
      w_word = 2'b00;
      case (r_mode_q)
         PAT_CLK:   w_word = 2'b01;
         PAT_PRBS7: w_word = w_prbs;
         PAT_FIXED: w_word = r_fixed;
         default:   w_word = 2'b00;
      endcase
   end

   // A stop edge registers 2'b00 rather than another pattern word
   always_comb begin
      w_src = 2'b00;
      case (r_state)
         ST_IDLE: if (pat_mode_e'(bus.pat_mode) == PAT_FUNC) w_src = {bus.idat1, bus.idat0};
         ST_RUN:  if (!bus.pat_stop) w_src = w_word;
         default: w_src = 2'b00;
      endcase
   end

   always_ff @(posedge ilaunch_clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_mode_q <= PAT_FUNC;
         r_fixed  <= 2'b00;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_cont   <= 1'b0;
         r_end    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_idat0q <= 1'b0;
         r_idat1q <= 1'b0;
      end else begin
         r_idat0q <= bus.tx_en & w_src[0];
         r_idat1q <= bus.tx_en & w_src[1];
         // busy/done are registered views of the state, one edge behind it
         r_busy   <= (r_state != ST_IDLE);
         r_done   <= r_end;
         r_end    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.pat_start && pat_mode_e'(bus.pat_mode) != PAT_FUNC)
                  r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_mode_q <= pat_mode_e'(bus.pat_mode);
               r_fixed  <= bus.pat_seed[1:0];
               r_rem    <= bus.burst_len;
               r_cont   <= (bus.burst_len == '0);
               r_cnt    <= '0;
               r_state  <= ST_RUN;
            end
            ST_RUN: begin
               if (w_stop) begin
                  // stop wins over a coincident end of count: one done pulse
                  r_state <= ST_IDLE;
                  r_end   <= 1'b1;
               end else begin
                  if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
                  if (!r_cont)   r_rem <= r_rem - CNT_W'(1);
                  if (w_last) begin
                     r_state <= ST_IDLE;
                     r_end   <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // second DDR half: transparent while the clock is low, held through the high phase
   assign w_clk_n = ~ilaunch_clk;

   itrx_aib_phy_tx_latch u_lat (
      .i_en (w_clk_n),
      .i_d  (r_idat1q),
      .o_q  (w_idat1ql)
   );

   assign bus.idat0q   = r_idat0q;
   assign bus.idat1ql  = w_idat1ql;
   assign bus.pat_busy = r_busy;
   assign bus.pat_done = r_done;
   assign bus.pat_cnt  = r_cnt;
endmodule

// File: tb/tb_itrx_aib_phy_tx_ddr_src.sv
// Bench for itrx_aib_phy_tx_ddr_src: directed scenarios plus randomized runs,
// checked every cycle against an edge-indexed behavioural model.
module tb_itrx_aib_phy_tx_ddr_src;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;
   localparam int MAXE = 20000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   itrx_aib_phy_tx_ddr_src_if #(.CNT_W(CW)) bus();

   itrx_aib_phy_tx_ddr_src #(.PRBS_SEED_DEF(7'h7F), .CNT_W(CW)) dut (
      .ilaunch_clk (clk),
      .rst         (rst),
      .bus         (bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   int e = 0;    // edges seen by the driver
   int ce = 0;   // edges seen by the compare process

   // expected outputs after each edge
   bit         x_vld [MAXE];
   logic [1:0] x_dat [MAXE];
   bit         x_busy[MAXE];
   bit         x_done[MAXE];
   int         x_cnt [MAXE];

   // current/last run description
   int         m_k = -100;    // edge at which start was accepted
   int         m_end = -100;  // last edge spent in RUN
   int         m_cnt = 0;
   int         m_mode = 0;
   logic [1:0] m_fix = 2'b00;
   bit         m_bits[254];   // two full PRBS7 periods of output bits

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d actual=%0d expected=%0d", nm, e, act, exp);
      end
   endtask

   function automatic void gen_bits(input logic [6:0] seed);
      int s = int'(seed);
      for (int j = 0; j < 254; j++) begin
         int fb = ((s >> 6) ^ (s >> 5)) & 1;
         s = ((s << 1) | fb) & 127;
         m_bits[j] = fb[0];
      end
   endfunction

   function automatic logic [1:0] word_at(input int w);
      case (m_mode)
         1:       return 2'b01;
         2:       return {m_bits[(2*w+1) % 254], m_bits[(2*w) % 254]};
         3:       return m_fix;
         default: return 2'b00;
      endcase
   endfunction

   // Expectation for the coming edge from the inputs about to be sampled.
   task automatic model_step();
      int e1;
      logic [1:0] d;
      bit bz, dn, ld, rn;
      e1 = e + 1;
      if (e1 >= MAXE) return;
      d = 2'b00; bz = 0; dn = 0;
      if (rst) begin
         m_k = -100; m_end = -100; m_cnt = 0;
      end else begin
         ld = (e1 == m_k + 1);
         rn = (e1 >= m_k + 2) && (e1 <= m_end);
         dn = (e1 == m_end + 1);
         if (ld) m_cnt = 0;
         else if (rn) begin
            if (bus.pat_stop) m_end = e1;
            else begin
               d = word_at(e1 - m_k - 2);
               if (m_cnt < CMAX) m_cnt++;
            end
         end else begin
            if (bus.pat_mode == 2'd0) d = {bus.idat1, bus.idat0};
            else if (bus.pat_start) begin
               m_k    = e1;
               m_mode = int'(bus.pat_mode);
               m_fix  = bus.pat_seed[1:0];
               gen_bits((bus.pat_seed == 7'd0) ? 7'h7F : bus.pat_seed);
               m_end  = (bus.burst_len == '0) ? 32'h3fff_ffff : e1 + int'(bus.burst_len) + 1;
            end
         end
         bz = (e1 >= m_k + 1) && (e1 <= m_end);
         if (!bus.tx_en) d = 2'b00;
      end
      x_vld[e1] = 1; x_dat[e1] = d; x_busy[e1] = bz; x_done[e1] = dn; x_cnt[e1] = m_cnt;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      e++;
      #1;
   endtask

   // compare process: idat1ql must hold the previous word through the high
   // phase; everything else is checked in the low phase
   initial begin
      forever begin
         @(posedge clk);
         ce++;
         #1;
         if (ce < MAXE && x_vld[ce-1]) chk("idat1ql_hold", int'(bus.idat1ql), int'(x_dat[ce-1][1]));
         @(negedge clk);
         #1;
         if (ce < MAXE && x_vld[ce]) begin
            chk("idat0q",   int'(bus.idat0q),   int'(x_dat[ce][0]));
            chk("idat1ql",  int'(bus.idat1ql),  int'(x_dat[ce][1]));
            chk("pat_busy", int'(bus.pat_busy), int'(x_busy[ce]));
            chk("pat_done", int'(bus.pat_done), int'(x_done[ce]));
            chk("pat_cnt",  int'(bus.pat_cnt),  x_cnt[ce]);
         end
      end
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog edge=%0d actual=running expected=finished", e);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "timeout");
   end

   task automatic start_run(input int mode, input logic [6:0] seed, input int blen);
      bus.pat_mode = 2'(mode); bus.pat_seed = seed; bus.burst_len = CW'(blen);
      bus.pat_start = 1'b1;
      cyc();
      bus.pat_start = 1'b0;
      cyc();   // LOAD edge samples the same mode/seed/length
   endtask

   initial begin
      int k, done_e, cnt_at, bsy_at, nd, c0, j;
      logic [7:0] wb;
      logic [1:0] fa [3];
      int s;
      bus.tx_en = 1'b1; bus.idat0 = 1'b0; bus.idat1 = 1'b0; bus.pat_mode = 2'd0;
      bus.pat_start = 1'b0; bus.pat_stop = 1'b0; bus.pat_seed = 7'd0; bus.burst_len = '0;

      // model pins: first 8 bits from seed 7F, period 127 cycles (254 steps)
      gen_bits(7'h7F);
      for (int i = 0; i < 8; i++) wb[i] = m_bits[i];
      chk("model_first8", int'(wb), 8'h40);
      s = 127;
      for (int i = 0; i < 254; i++) s = ((s << 1) | (((s >> 6) ^ (s >> 5)) & 1)) & 127;
      chk("model_period", s, 127);

      rst = 1'b1;
      repeat (3) cyc();
      chk("rst_idat0q", int'(bus.idat0q), 0);
      chk("rst_busy",   int'(bus.pat_busy), 0);
      chk("rst_done",   int'(bus.pat_done), 0);
      chk("rst_cnt",    int'(bus.pat_cnt), 0);
      rst = 1'b0;
      cyc();

      // FUNC pass-through
      fa[0] = 2'b01; fa[1] = 2'b10; fa[2] = 2'b11;
      for (int i = 0; i < 3; i++) begin
         bus.idat0 = fa[i][0]; bus.idat1 = fa[i][1];
         cyc();
         chk("func_idat0q", int'(bus.idat0q), int'(fa[i][0]));
         @(negedge clk); #1;
         chk("func_idat1ql", int'(bus.idat1ql), int'(fa[i][1]));
      end
      bus.idat0 = 1'b0; bus.idat1 = 1'b0;
      cyc();

      // PRBS7 seed 7F, burst 200
      bus.pat_mode = 2'd2; bus.pat_seed = 7'h7F; bus.burst_len = CW'(200);
      bus.pat_start = 1'b1;
      cyc(); k = e;
      bus.pat_start = 1'b0;
      cyc();
      done_e = -1; cnt_at = -1; bsy_at = -1; wb = '0;
      for (int i = 0; i < 260 && done_e < 0; i++) begin
         cyc();
         if (bus.pat_done) begin done_e = e; cnt_at = int'(bus.pat_cnt); bsy_at = int'(bus.pat_busy); end
         if (e - k >= 2 && e - k <= 5) begin
            j = 2 * (e - k - 2);
            wb[j] = bus.idat0q;
            @(negedge clk); #1;
            wb[j+1] = bus.idat1ql;
         end
      end
      chk("prbs_first8", int'(wb), 8'h40);
      chk("prbs_done_edge", done_e - k, 202);
      chk("prbs_cnt", cnt_at, 200);
      chk("prbs_busy_end", bsy_at, 0);
      bus.pat_mode = 2'd0;
      repeat (2) cyc();

      // CLK continuous 50 cycles, then stop
      start_run(1, 7'd0, 0);
      repeat (50) begin
         cyc();
         chk("clk_idat0q", int'(bus.idat0q), 1);
      end
      bus.pat_stop = 1'b1;
      cyc();
      bus.pat_stop = 1'b0;
      chk("clk_stop_idat0q", int'(bus.idat0q), 0);
      nd = 0;
      repeat (4) begin cyc(); nd += int'(bus.pat_done); end
      chk("clk_stop_done", nd, 1);

      // continuous run long enough to saturate the counter
      start_run(1, 7'd0, 0);
      repeat (270) cyc();
      chk("cnt_saturate", int'(bus.pat_cnt), CMAX);
      bus.pat_stop = 1'b1; cyc(); bus.pat_stop = 1'b0;
      repeat (3) cyc();

      // seed zero substitutes the default; start/mode change while busy ignored
      start_run(2, 7'd0, 30);
      repeat (4) cyc();   // word 3 of the default stream: idat0 = 1
      chk("seed0_word3", int'(bus.idat0q), 1);
      bus.pat_start = 1'b1; bus.pat_mode = 2'd3;
      cyc();
      bus.pat_start = 1'b0;
      repeat (30) cyc();
      bus.pat_mode = 2'd0;
      cyc();

      // reset in the middle of a PRBS run
      start_run(2, 7'h05, 50);
      repeat (10) cyc();
      rst = 1'b1;
      cyc();
      chk("midrst_idat0q", int'(bus.idat0q), 0);
      chk("midrst_busy",   int'(bus.pat_busy), 0);
      chk("midrst_cnt",    int'(bus.pat_cnt), 0);
      rst = 1'b0;
      bus.pat_mode = 2'd0;
      nd = int'(bus.pat_done);
      repeat (4) begin cyc(); nd += int'(bus.pat_done); end
      chk("midrst_no_done", nd, 0);

      // output enable low during FIXED 2'b11
      start_run(3, 7'h03, 20);
      repeat (4) cyc();
      chk("fixed_idat0q", int'(bus.idat0q), 1);
      c0 = int'(bus.pat_cnt);
      bus.tx_en = 1'b0;
      repeat (6) begin
         cyc();
         chk("txen_idat0q", int'(bus.idat0q), 0);
      end
      @(negedge clk); #1;
      chk("txen_idat1ql", int'(bus.idat1ql), 0);
      chk("txen_cnt_runs", int'(bus.pat_cnt) - c0, 6);
      bus.tx_en = 1'b1;
      repeat (15) cyc();
      bus.pat_mode = 2'd0;
      cyc();

      // randomized runs
      for (int r = 0; r < 30; r++) begin
         int n, total, stop_at, gap;
         gap = $urandom_range(1, 4);
         for (int g = 0; g < gap; g++) begin
            bus.pat_mode = 2'($urandom_range(0, 3));
            bus.idat0 = 1'($urandom); bus.idat1 = 1'($urandom);
            bus.tx_en = ($urandom_range(0, 7) != 0);
            bus.pat_stop = ($urandom_range(0, 3) == 0);
            cyc();
         end
         bus.pat_stop = 1'b0;
         n = $urandom_range(0, 25);
         start_run($urandom_range(1, 3), ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom), n);
         total = (n == 0) ? $urandom_range(1, 40) : n;
         stop_at = (n == 0) ? total : ((n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1);
         for (int i = 1; i <= total; i++) begin
            if ($urandom_range(0, 99) == 0) begin
               rst = 1'b1; bus.pat_start = 1'b0; bus.pat_stop = 1'b0;
               cyc();
               rst = 1'b0;
               break;
            end
            bus.tx_en = ($urandom_range(0, 7) != 0);
            bus.pat_mode = 2'($urandom_range(0, 3));
            bus.idat0 = 1'($urandom); bus.idat1 = 1'($urandom);
            bus.pat_start = (i < total) && ($urandom_range(0, 5) == 0);
            bus.pat_stop = (i == stop_at);
            cyc();
            if (i == stop_at) break;
         end
         bus.pat_start = 1'b0; bus.pat_stop = 1'b0; bus.tx_en = 1'b1;
         cyc();
      end

      bus.pat_mode = 2'd0;
      repeat (3) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
